mask_collector: RTL

- Consumes the per-pixel mask stream (valid/mask/mask_x/mask_y) produced by the mask generator.
- Packs 16 horizontally adjacent mask bits into one word. Computes the word's frame-buffer address and queues {addr,data} in a small FIFO. The FIFO drains to the SRAM arbiter over a req/ack handshake.
- Also counts foreground pixels (mask==0) per frame and reports the total at frame end for the ALT side.

---
 rtl/mask_collector_if.sv | 27 ++
 rtl/mask_collector.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mask_collector_if.sv
// Pixel-mask input stream, word-write handshake and frame statistics of mask_collector.
interface mask_collector_if #(
  parameter int ADDR_W = 15
);
  logic              valid;
  logic              mask;
  logic [9:0]        mask_x;
  logic [9:0]        mask_y;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              clr_ovf;
  logic              overflow;
  logic              frame_done;
  logic [18:0]       fg_count;

  modport master (
    output valid, mask, mask_x, mask_y, wr_ack, clr_ovf,
    input  wr_req, wr_addr, wr_data, overflow, frame_done, fg_count
  );

  modport slave (
    input  valid, mask, mask_x, mask_y, wr_ack, clr_ovf,
    output wr_req, wr_addr, wr_data, overflow, frame_done, fg_count
  );
endinterface

// File: rtl/mask_collector.sv
// Packs 16 adjacent mask bits into addressed words queued in a small FIFO towards the
// SRAM arbiter, and reports the per-frame foreground pixel count.
module mask_collector #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic           clk_25,
  input  logic           rst_n,
  mask_collector_if.slave bus
);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WPL = H_ACTIVE / 16;
  localparam logic [18:0] CNT_MAX = 19'h7FFFF;

  logic [15:0]       r_word;
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [15:0]       r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic [18:0]       r_run;
  logic              r_wr_req;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_overflow;
  logic              r_frame_done;
  logic [18:0]       r_fg_count;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_last;
  logic              w_bypass;
  logic [15:0]       w_word_new;
  logic [ADDR_W-1:0] w_addr;
  logic [18:0]       w_run_inc;
  logic [PW-1:0]     w_rptr_nxt;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_accept   = bus.valid && (bus.mask_x < 10'(H_ACTIVE)) && (bus.mask_y < 10'(V_ACTIVE));
  assign w_push     = w_accept && (bus.mask_x[3:0] == 4'd15);
  assign w_pop      = r_wr_req && bus.wr_ack;
  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_last     = w_accept && (bus.mask_x == 10'(H_ACTIVE - 1)) && (bus.mask_y == 10'(V_ACTIVE - 1));
  assign w_addr     = ADDR_W'(bus.mask_y) * ADDR_W'(WPL) + ADDR_W'(bus.mask_x[9:4]);
  assign w_run_inc  = (w_accept && !bus.mask && (r_run != CNT_MAX)) ? r_run + 19'd1 : r_run;
  assign w_rptr_nxt = w_pop ? r_rptr + PW'(1) : r_rptr;
  assign w_cnt_nxt  = r_cnt + CW'(w_push_ok) - CW'(w_pop);
  // The pushed word becomes the head when it lands in the slot the read pointer moves to.
  assign w_bypass   = w_push_ok && (r_wptr == w_rptr_nxt);

  // Assembly word with this cycle's pixel merged in.
  always_comb begin
    w_word_new = r_word;
    w_word_new[bus.mask_x[3:0]] = bus.mask;
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_25) begin
    if (w_push_ok) begin
      r_mem_addr[r_wptr] <= w_addr;
      r_mem_data[r_wptr] <= w_word_new;
    end
  end

  // Packing, FIFO control, registered head, overflow flag and frame counting.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= 16'hFFFF;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_run        <= 19'd0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 16'h0000;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_fg_count   <= 19'd0;
    end else begin
      if (w_accept) begin
        r_word <= w_push ? 16'hFFFF : w_word_new;
      end
      if (w_push_ok) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr   <= w_rptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr_req <= (w_cnt_nxt != CW'(0));
      if (w_bypass) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_word_new;
      end else if (w_cnt_nxt != CW'(0)) begin
        r_wr_addr <= r_mem_addr[w_rptr_nxt];
        r_wr_data <= r_mem_data[w_rptr_nxt];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
      r_frame_done <= w_last;
      if (w_last) begin
        r_fg_count <= w_run_inc;
        r_run      <= 19'd0;
      end else begin
        r_run      <= w_run_inc;
      end
    end
  end

  assign bus.wr_req     = r_wr_req;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.overflow   = r_overflow;
  assign bus.frame_done = r_frame_done;
  assign bus.fg_count   = r_fg_count;
endmodule
